// File: rtl/exception_sequencer_pkg.sv
// Shared types and constants for the exception sequencer: FSM state encoding,
// cause codes, default vector table base and the cause priority encoder.
package exception_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSave = 3'd1,
    StWait = 3'd2,
    StLoad = 3'd3,
    StDone = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CauseNone   = 2'b00,
    CauseOpcode = 2'b01,
    CauseOvf    = 2'b10,
    CauseDiv0   = 2'b11
  } cause_e;

  // Byte address of the opcode vector; ovf and div0 follow at +1 and +2.
  localparam int unsigned VEC_BASE_DEFAULT = 253;

  // Priority opcode > ovf > div0; lower-priority requests are dropped.
  function automatic logic [1:0] pick_cause(input logic opcode, input logic ovf,
                                            input logic div0);
    logic [1:0] c;
    c = CauseNone;
    if (opcode)    c = CauseOpcode;
    else if (ovf)  c = CauseOvf;
    else if (div0) c = CauseDiv0;
    return c;
  endfunction

endpackage

// File: rtl/exception_sequencer.sv
// Exception sequencer for the multicycle MIPS datapath: on an exception
// request it saves EPC, reads the handler byte from the vector table and
// steers the PC-source mux so the next PC write takes the vector value.
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,      // active-low, asynchronous
  input  logic        i_exc_opcode,
  input  logic        i_exc_ovf,
  input  logic        i_exc_div0,
  input  logic [31:0] i_pc_in,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic [31:0] o_epc_out,
  output logic        o_epc_write,
  output logic [31:0] o_vec_out,
  output logic        o_ex_sel,
  output logic        o_pc_write,
  output logic [1:0]  o_cause,
  output logic        o_busy
);

  // Counter preload: WAIT lasts MEM_LAT cycles, leaving when it reads 0.
  localparam logic [1:0] WaitLoad = 2'(MEM_LAT - 1);

  state_e      r_state;
  logic [1:0]  r_wait_cnt;
  logic [31:0] r_mem_addr;
  logic        r_mem_rd;
  logic [31:0] r_epc_out;
  logic        r_epc_write;
  logic [31:0] r_vec_out;
  logic        r_ex_sel;
  logic        r_pc_write;
  logic [1:0]  r_cause;
  logic        r_busy;

  logic        w_req;
  logic [1:0]  w_cause;
  logic        w_unused_rdata;

  // Request detection and priority selection.
  always_comb begin
    w_req   = i_exc_opcode | i_exc_ovf | i_exc_div0;
    w_cause = pick_cause(i_exc_opcode, i_exc_ovf, i_exc_div0);
  end

  // Only the low byte of the vector entry is used.
  assign w_unused_rdata = ^i_mem_rdata[31:8];

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_wait_cnt  <= 2'd0;
      r_mem_addr  <= 32'd0;
      r_mem_rd    <= 1'b0;
      r_epc_out   <= 32'd0;
      r_epc_write <= 1'b0;
      r_vec_out   <= 32'd0;
      r_ex_sel    <= 1'b0;
      r_pc_write  <= 1'b0;
      r_cause     <= CauseNone;
      r_busy      <= 1'b0;
    end else begin
      // Write enables are single-cycle pulses unless re-asserted below.
      r_epc_write <= 1'b0;
      r_pc_write  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            r_cause     <= w_cause;
            r_epc_out   <= i_pc_in - 32'd4;
            r_mem_addr  <= 32'(VEC_BASE) + {30'd0, w_cause} - 32'd1;
            r_mem_rd    <= 1'b1;
            r_epc_write <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StSave;
          end
        end
        StSave: begin
          r_wait_cnt <= WaitLoad;
          r_state    <= StWait;
        end
        StWait: begin
          if (r_wait_cnt == 2'd0) begin
            r_mem_rd   <= 1'b0;
            r_vec_out  <= {24'd0, i_mem_rdata[7:0]};
            r_ex_sel   <= 1'b1;
            r_pc_write <= 1'b1;
            r_state    <= StLoad;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        StLoad: begin
          r_ex_sel <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= StDone;
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_rd    = r_mem_rd;
  assign o_epc_out   = r_epc_out;
  assign o_epc_write = r_epc_write;
  assign o_vec_out   = r_vec_out;
  assign o_ex_sel    = r_ex_sel;
  assign o_pc_write  = r_pc_write;
  assign o_cause     = r_cause;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: table-driven exception transactions on a
// MEM_LAT=1 instance plus hand-written reset-mid-WAIT and MEM_LAT=3 sequences.
module tb_exception_sequencer;

  typedef struct {
    string       name;
    logic        op;
    logic        ovf;
    logic        div0;
    logic        pulse;   // pulse exc_div0 again while busy
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [1:0]  exp_cause;
    logic [31:0] exp_epc;
    logic [31:0] exp_addr;
    logic [31:0] exp_vec;
  } vec_t;

  logic clk;
  logic reset;

  // MEM_LAT = 1 instance
  logic        exc_opcode, exc_ovf, exc_div0;
  logic [31:0] pc_in, mem_rdata;
  logic [31:0] mem_addr, epc_out, vec_out;
  logic        mem_rd, epc_write, ex_sel, pc_write, busy;
  logic [1:0]  cause;

  // MEM_LAT = 3 instance
  logic        t3_exc_opcode, t3_exc_ovf, t3_exc_div0;
  logic [31:0] t3_pc_in, t3_mem_rdata;
  logic [31:0] t3_mem_addr, t3_epc_out, t3_vec_out;
  logic        t3_mem_rd, t3_epc_write, t3_ex_sel, t3_pc_write, t3_busy;
  logic [1:0]  t3_cause;

  int n_checks = 0;
  int n_fail   = 0;

  exception_sequencer #(.MEM_LAT(1), .VEC_BASE(253)) u_dut1 (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_exc_opcode (exc_opcode),
    .i_exc_ovf    (exc_ovf),
    .i_exc_div0   (exc_div0),
    .i_pc_in      (pc_in),
    .i_mem_rdata  (mem_rdata),
    .o_mem_addr   (mem_addr),
    .o_mem_rd     (mem_rd),
    .o_epc_out    (epc_out),
    .o_epc_write  (epc_write),
    .o_vec_out    (vec_out),
    .o_ex_sel     (ex_sel),
    .o_pc_write   (pc_write),
    .o_cause      (cause),
    .o_busy       (busy)
  );

  exception_sequencer #(.MEM_LAT(3), .VEC_BASE(253)) u_dut3 (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_exc_opcode (t3_exc_opcode),
    .i_exc_ovf    (t3_exc_ovf),
    .i_exc_div0   (t3_exc_div0),
    .i_pc_in      (t3_pc_in),
    .i_mem_rdata  (t3_mem_rdata),
    .o_mem_addr   (t3_mem_addr),
    .o_mem_rd     (t3_mem_rd),
    .o_epc_out    (t3_epc_out),
    .o_epc_write  (t3_epc_write),
    .o_vec_out    (t3_vec_out),
    .o_ex_sel     (t3_ex_sel),
    .o_pc_write   (t3_pc_write),
    .o_cause      (t3_cause),
    .o_busy       (t3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_addr"},  mem_addr, 32'd0);
    check({tag, " mem_rd"},    {31'd0, mem_rd}, 32'd0);
    check({tag, " epc_out"},   epc_out, 32'd0);
    check({tag, " epc_write"}, {31'd0, epc_write}, 32'd0);
    check({tag, " vec_out"},   vec_out, 32'd0);
    check({tag, " ex_sel"},    {31'd0, ex_sel}, 32'd0);
    check({tag, " pc_write"},  {31'd0, pc_write}, 32'd0);
    check({tag, " cause"},     {30'd0, cause}, 32'd0);
    check({tag, " busy"},      {31'd0, busy}, 32'd0);
  endtask

  // One complete exception on the MEM_LAT=1 instance; starts just after a posedge.
  task automatic run_vec(input vec_t v);
    int  lat;
    bit  seen;
    int  extra;
    exc_opcode = v.op;
    exc_ovf    = v.ovf;
    exc_div0   = v.div0;
    pc_in      = v.pc;
    mem_rdata  = v.rdata;
    @(posedge clk); #1;
    exc_opcode = 1'b0;
    exc_ovf    = 1'b0;
    exc_div0   = 1'b0;
    // SAVE
    check({v.name, " epc_write"}, {31'd0, epc_write}, 32'd1);
    check({v.name, " epc_out"},   epc_out, v.exp_epc);
    check({v.name, " mem_addr"},  mem_addr, v.exp_addr);
    check({v.name, " mem_rd"},    {31'd0, mem_rd}, 32'd1);
    check({v.name, " busy save"}, {31'd0, busy}, 32'd1);
    check({v.name, " cause"},     {30'd0, cause}, {30'd0, v.exp_cause});
    if (v.pulse) exc_div0 = 1'b1;
    lat  = 1;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(posedge clk); #1;
      exc_div0 = 1'b0;
      lat++;
      if (lat == 2) check({v.name, " epc_write single"}, {31'd0, epc_write}, 32'd0);
      if (pc_write) seen = 1'b1;
    end
    // LOAD
    check({v.name, " pc_write latency"}, lat, 32'd3);
    check({v.name, " vec_out"},   vec_out, v.exp_vec);
    check({v.name, " ex_sel"},    {31'd0, ex_sel}, 32'd1);
    check({v.name, " busy load"}, {31'd0, busy}, 32'd1);
    // DONE
    @(posedge clk); #1;
    check({v.name, " pc_write single"}, {31'd0, pc_write}, 32'd0);
    check({v.name, " ex_sel done"},     {31'd0, ex_sel}, 32'd0);
    check({v.name, " busy done"},       {31'd0, busy}, 32'd0);
    check({v.name, " vec_out held"},    vec_out, v.exp_vec);
    check({v.name, " epc_out held"},    epc_out, v.exp_epc);
    // No queued request may start a second sequence.
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (pc_write || epc_write || busy) extra++;
    end
    check({v.name, " no extra activity"}, extra, 32'd0);
  endtask

  vec_t vecs[5];
  vec_t v_post;

  initial begin
    int  lat;
    bit  seen;

    vecs[0] = '{"opcode",     1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_00A4,
                2'b01, 32'h0000_003C, 32'd253, 32'h0000_00A4};
    vecs[1] = '{"ovf+div0",   1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h1234_5633,
                2'b10, 32'h0000_0FFC, 32'd254, 32'h0000_0033};
    vecs[2] = '{"div0 pc0",   1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_00E0,
                2'b11, 32'hFFFF_FFFC, 32'd255, 32'h0000_00E0};
    vecs[3] = '{"all three",  1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0004, 32'hABCD_EF01,
                2'b01, 32'h8000_0000, 32'd253, 32'h0000_0001};
    vecs[4] = '{"ovf odd pc", 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0055,
                2'b10, 32'hDEAD_BEEB, 32'd254, 32'h0000_0055};
    v_post  = '{"ovf after reset", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_00C8,
                2'b10, 32'h0000_1FFC, 32'd254, 32'h0000_00C8};

    reset         = 1'b0;
    exc_opcode    = 1'b0;
    exc_ovf       = 1'b0;
    exc_div0      = 1'b0;
    pc_in         = 32'd0;
    mem_rdata     = 32'd0;
    t3_exc_opcode = 1'b0;
    t3_exc_ovf    = 1'b0;
    t3_exc_div0   = 1'b0;
    t3_pc_in      = 32'd0;
    t3_mem_rdata  = 32'd0;

    #12;
    check_all_zero("reset");
    check("reset t3 busy",  {31'd0, t3_busy}, 32'd0);
    check("reset t3 cause", {30'd0, t3_cause}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted while in WAIT cancels the pending pc_write.
    exc_ovf   = 1'b1;
    pc_in     = 32'h0000_0100;
    mem_rdata = 32'h0000_0099;
    @(posedge clk); #1;
    exc_ovf = 1'b0;
    @(posedge clk); #1;
    check("midwait mem_rd", {31'd0, mem_rd}, 32'd1);
    check("midwait busy",   {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check_all_zero("midwait reset");
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (pc_write || busy) seen = 1'b1;
    end
    check("midwait cancelled", {31'd0, seen}, 32'd0);
    run_vec(v_post);

    // MEM_LAT = 3: pc_write five cycles after the request.
    t3_exc_ovf   = 1'b1;
    t3_pc_in     = 32'h0000_0200;
    t3_mem_rdata = 32'hFFFF_FF7C;
    @(posedge clk); #1;
    t3_exc_ovf = 1'b0;
    check("lat3 epc_write", {31'd0, t3_epc_write}, 32'd1);
    check("lat3 epc_out",   t3_epc_out, 32'h0000_01FC);
    lat  = 1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      lat++;
      if (t3_pc_write) begin
        seen = 1'b1;
      end else begin
        check("lat3 mem_rd held",   {31'd0, t3_mem_rd}, 32'd1);
        check("lat3 mem_addr held", t3_mem_addr, 32'd254);
        check("lat3 busy",          {31'd0, t3_busy}, 32'd1);
      end
    end
    check("lat3 pc_write latency", lat, 32'd5);
    check("lat3 vec_out", t3_vec_out, 32'h0000_007C);
    check("lat3 ex_sel",  {31'd0, t3_ex_sel}, 32'd1);
    check("lat3 cause",   {30'd0, t3_cause}, 32'd2);
    @(posedge clk); #1;
    check("lat3 pc_write single", {31'd0, t3_pc_write}, 32'd0);
    check("lat3 busy done",       {31'd0, t3_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Upstream controller for the PC-source exception mux in the multicycle MIPS datapath.
- Detects an exception request and saves EPC.
- Fetches the handler byte from the exception vector table in memory.
- Drives the mux select so the next PC write takes the vector value instead of the normal PC source.
- Sits between the main control unit (exception flags, busy/stall) and the PC/EPC registers and memory port.

Parameters:
- MEM_LAT, 1, read latency in cycles from mem_addr valid to mem_rdata valid (range 1-4).
- VEC_BASE, 253, byte address of the first vector entry (opcode = base, overflow = base+1, div0 = base+2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- exc_opcode  in  1  invalid-opcode request, sampled in IDLE.
- exc_ovf  in  1  arithmetic overflow request, sampled in IDLE.
- exc_div0  in  1  divide-by-zero request, sampled in IDLE.
- pc_in  in  32  current PC (already incremented by 4).
- mem_rdata  in  32  memory read data.
- mem_addr  out  32  vector table read address.
- mem_rd  out  1  memory read strobe.
- epc_out  out  32  value to load into EPC.
- epc_write  out  1  EPC write enable.
- vec_out  out  32  handler address, feeds the mux memory-data input.
- ex_sel  out  1  mux select: 0 = PC source, 1 = vec_out.
- pc_write  out  1  PC write enable for the handler jump.
- cause  out  2  latched cause: 00 none, 01 opcode, 10 ovf, 11 div0.
- busy  out  1  high while sequencing; control unit must stall.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; cause=00; wait counter=0.
- IDLE:
  - If any exc_* is high, latch the cause with priority opcode > ovf > div0, latch pc_in, and go to SAVE.
  - Requests arriving in any other state are ignored; there is no queueing.
- SAVE (1 cycle):
  - epc_write=1; epc_out=latched pc_in-4 (32-bit, wraps modulo 2^32, so pc_in=0 gives 0xFFFFFFFC).
  - mem_addr=VEC_BASE+cause-1; mem_rd=1; busy=1.
- WAIT (MEM_LAT cycles):
  - mem_rd stays 1; mem_addr is held; busy=1; the counter decrements to 0.
- LOAD (1 cycle):
  - vec_out={24'b0, mem_rdata[7:0]}, registered at entry and held until the next exception.
  - ex_sel=1; pc_write=1; busy=1.
- DONE (1 cycle): ex_sel=0; pc_write=0; busy=0; then IDLE.
- Outputs:
  - All outputs are registered.
  - epc_write and pc_write are single-cycle pulses.
  - epc_out and cause are held until the next exception.
- Latency: request high at edge N gives epc_write at N+1 and pc_write at N+2+MEM_LAT.
- Simultaneous requests: only the highest-priority cause is serviced; the others are dropped.
- Reset mid-sequence: immediate return to IDLE.
  - Any pending pc_write/epc_write is cancelled asynchronously.
  - cause returns to 00.
- busy rises in the cycle after detection and falls in DONE.
  - The control unit must hold its flags low or ignore them while busy=1.

Decomposition:
- Shared package:
  - state encoding (IDLE, SAVE, WAIT, LOAD, DONE);
  - cause codes;
  - VEC_BASE default.
- No sub-module needed; the wait counter is inline.

Test Plan:
- Reset asserted mid-WAIT -> all outputs 0 within the same cycle; state IDLE; a new exc_ovf afterwards is serviced normally.
- exc_opcode=1, pc_in=0x00000040, MEM_LAT=1, mem_rdata=0x000000A4 -> next cycle epc_write=1, epc_out=0x3C, mem_addr=253; two cycles later pc_write=1, ex_sel=1, vec_out=0xA4, cause=01.
- exc_ovf and exc_div0 high in the same cycle -> cause=10, mem_addr=254; div0 is never serviced.
- exc_div0 pulsed again while busy=1 -> ignored; exactly one pc_write pulse is seen.
- pc_in=0x00000000, exc_div0 -> epc_out=0xFFFFFFFC, mem_addr=255.
- MEM_LAT=3 -> pc_write occurs 5 cycles after the request; mem_rdata=0xFFFFFF7C gives vec_out=0x0000007C.
